// File: rtl/aoc_pkg.sv
// Shared definitions for the day-1 datapath (sorter and similarity scorer).
//   ADDR_W / DATA_W     : memory address and data widths used by both blocks
//   SCORER_LEN_W / ACC_W: default list-length and accumulator widths
//   scorer_state_t      : similarity_scorer FSM states
package aoc_pkg;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int SCORER_LEN_W = 16;
  localparam int SCORER_ACC_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CMP,
    RUN_B,
    RUN_B_WAIT,
    APPLY_A,
    APPLY_A_WAIT
  } scorer_state_t;

endpackage : aoc_pkg

// File: rtl/similarity_scorer.sv
// similarity_scorer: single merge pass over two sorted read-only memories.
// For every left value v it accumulates v * (occurrences of v in the right
// list) and presents the result with a level done flag.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   go             start pulse, sampled only in IDLE
//   len_a, len_b   entry counts of the A (left) and B (right) memories
//   addr_a, data_a A read port (1-cycle synchronous read latency)
//   addr_b, data_b B read port (1-cycle synchronous read latency)
//   busy           high from go acceptance until completion
//   done           set on completion, held until the next accepted go
//   score          similarity score, valid while done = 1
module similarity_scorer
  import aoc_pkg::*;
#(
  parameter int LEN_W = SCORER_LEN_W,
  parameter int ACC_W = SCORER_ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [LEN_W-1:0]  len_a,
  input  logic [LEN_W-1:0]  len_b,
  output logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  score
);

  scorer_state_t     state, state_nxt;
  logic [LEN_W-1:0]  i, j;
  logic [DATA_W-1:0] key;
  logic [LEN_W-1:0]  cnt;

  // Range checks come first so data at address == length never decides
  // anything: the AND masks the data compare once a pointer hits its end.
  logic at_end, b_match, a_match;
  assign at_end  = (i == len_a) || (j == len_b);
  assign b_match = (j < len_b) && (data_b == key);
  assign a_match = (i < len_a) && (data_a == key);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of the others, independent of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:         if (go) state_nxt = FETCH;
      FETCH:        state_nxt = CMP;
      CMP: begin
        if (at_end)                state_nxt = IDLE;
        else if (data_a != data_b) state_nxt = FETCH;
        else                       state_nxt = RUN_B;
      end
      RUN_B:        state_nxt = b_match ? RUN_B_WAIT : APPLY_A;
      RUN_B_WAIT:   state_nxt = RUN_B;
      // Both addresses have been stable for at least a cycle here, so the
      // data seen on the exit to CMP is already valid; no refetch needed.
      APPLY_A:      state_nxt = a_match ? APPLY_A_WAIT : CMP;
      APPLY_A_WAIT: state_nxt = APPLY_A;
      default:      state_nxt = IDLE;
    endcase
  end

  // Datapath registers: pointers, run key/count, accumulator and done flag.
  // Each *_WAIT state gives the memory one cycle to return the word at the
  // pointer that was just advanced.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i     <= '0;
      j     <= '0;
      key   <= '0;
      cnt   <= '0;
      score <= '0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            i     <= '0;
            j     <= '0;
            score <= '0;
            done  <= 1'b0;
          end
        end
        CMP: begin
          if (at_end)                done <= 1'b1;
          else if (data_a < data_b)  i    <= i + LEN_W'(1);
          else if (data_a > data_b)  j    <= j + LEN_W'(1);
          else begin
            key <= data_a;
            cnt <= '0;
          end
        end
        RUN_B: begin
          if (b_match) begin
            cnt <= cnt + LEN_W'(1);
            j   <= j + LEN_W'(1);
          end
        end
        APPLY_A: begin
          // Unsigned 32 x LEN_W product, zero-extended; the sum wraps at ACC_W.
          if (a_match) begin
            score <= score + (ACC_W'(key) * ACC_W'(cnt));
            i     <= i + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs derived from state and pointers.
  always_comb begin
    busy   = (state != IDLE);
    addr_a = ADDR_W'(i);
    addr_b = ADDR_W'(j);
  end

endmodule : similarity_scorer

// File: tb/tb_similarity_scorer.sv
// Self-checking bench for similarity_scorer: table-driven directed vectors,
// hand-written corner sequences, and randomized sorted lists checked against
// a count-and-multiply reference model.
module tb_similarity_scorer;
  import aoc_pkg::*;

  localparam int LEN_W = 16;
  localparam int ACC_W = 64;
  localparam int DEPTH = 16;
  localparam int BUDGET = 3000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              go = 1'b0;
  logic [LEN_W-1:0]  len_a = '0, len_b = '0;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a = '0, data_b = '0;
  logic              busy, done;
  logic [ACC_W-1:0]  score;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  similarity_scorer #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .go(go),
    .len_a(len_a), .len_b(len_b),
    .addr_a(addr_a), .data_a(data_a),
    .addr_b(addr_b), .data_b(data_b),
    .busy(busy), .done(done), .score(score)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories, 1-cycle latency.
  always @(posedge clk) begin
    data_a <= mem_a[addr_a[3:0]];
    data_b <= mem_b[addr_b[3:0]];
  end

  task automatic check(input string name, input logic [ACC_W-1:0] act,
                       input logic [ACC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Addresses must never run past the list lengths while a pass is active.
  always @(negedge clk) begin
    if (reset && busy) begin
      check("addr_a_bound", 64'(addr_a <= 32'(len_a)), 64'd1);
      check("addr_b_bound", 64'(addr_b <= 32'(len_b)), 64'd1);
    end
  end

  typedef struct packed {
    logic [3:0]             la;
    logic [3:0]             lb;
    logic [7:0][DATA_W-1:0] a;
    logic [7:0][DATA_W-1:0] b;
    logic [ACC_W-1:0]       exp;
  } vec_t;

  vec_t vecs [4];

  // Unused memory slots get junk so any read past the length would show.
  task automatic fill_junk();
    for (int k = 0; k < DEPTH; k++) begin
      mem_a[k] = $urandom_range(0, 9);
      mem_b[k] = $urandom_range(0, 9);
    end
  endtask

  task automatic load_vec(input vec_t v);
    fill_junk();
    for (int k = 0; k < 8; k++) begin
      if (k < int'(v.la)) mem_a[k] = v.a[k];
      if (k < int'(v.lb)) mem_b[k] = v.b[k];
    end
    len_a = LEN_W'(v.la);
    len_b = LEN_W'(v.lb);
  endtask

  // Pulse go for one edge; returns #1 after that (edge 1).
  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  // Wait for done, counting edges with the go edge as edge 1.
  task automatic wait_done(input string name, output int edges);
    edges = 1;
    while (!done && edges < BUDGET) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({name, "_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic run(input string name, input logic [ACC_W-1:0] exp,
                     output int edges);
    pulse_go();
    wait_done(name, edges);
    check({name, "_score"}, score, exp);
    check({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Reference: sum over A of v * count(v in B), modulo 2^64.
  function automatic logic [ACC_W-1:0] model(input logic [DATA_W-1:0] qa[$],
                                             input logic [DATA_W-1:0] qb[$]);
    logic [ACC_W-1:0] acc = '0;
    foreach (qa[x]) begin
      int c = 0;
      foreach (qb[y]) if (qb[y] == qa[x]) c++;
      acc += ACC_W'(qa[x]) * ACC_W'(c);
    end
    return acc;
  endfunction

  initial begin
    int edges, ref_edges;
    logic [DATA_W-1:0] qa[$], qb[$];
    logic [DATA_W-1:0] v;

    // Directed vectors.
    vecs[0] = '0; vecs[0].la = 6; vecs[0].lb = 6; vecs[0].exp = 64'd31;
    vecs[0].a[0] = 1; vecs[0].a[1] = 2; vecs[0].a[2] = 3;
    vecs[0].a[3] = 3; vecs[0].a[4] = 3; vecs[0].a[5] = 4;
    vecs[0].b[0] = 3; vecs[0].b[1] = 3; vecs[0].b[2] = 3;
    vecs[0].b[3] = 4; vecs[0].b[4] = 5; vecs[0].b[5] = 9;
    vecs[1] = '0; vecs[1].la = 2; vecs[1].lb = 2; vecs[1].exp = 64'd0;
    vecs[1].a[0] = 1; vecs[1].a[1] = 2; vecs[1].b[0] = 5; vecs[1].b[1] = 6;
    vecs[2] = '0; vecs[2].la = 1; vecs[2].lb = 3; vecs[2].exp = 64'h2_FFFF_FFFD;
    vecs[2].a[0] = 32'hFFFF_FFFF;
    vecs[2].b[0] = 32'hFFFF_FFFF; vecs[2].b[1] = 32'hFFFF_FFFF;
    vecs[2].b[2] = 32'hFFFF_FFFF;
    vecs[3] = '0; vecs[3].la = 3; vecs[3].lb = 4; vecs[3].exp = 64'd19;
    vecs[3].a[0] = 2; vecs[3].a[1] = 2; vecs[3].a[2] = 5;
    vecs[3].b[0] = 2; vecs[3].b[1] = 5; vecs[3].b[2] = 5; vecs[3].b[3] = 5;

    fill_junk();
    #12;
    check("rst_done",   64'(done),   64'd0);
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_score",  score,       64'd0);
    check("rst_addr_a", 64'(addr_a), 64'd0);
    check("rst_addr_b", 64'(addr_b), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    ref_edges = 0;
    for (int n = 0; n < 4; n++) begin
      load_vec(vecs[n]);
      run($sformatf("vec%0d", n), vecs[n].exp, edges);
      if (n == 0) ref_edges = edges;
    end

    // Empty A list: done rises on edge 3, addresses stay at 0.
    fill_junk();
    len_a = '0;
    len_b = 16'd4;
    pulse_go();
    check("empty_e1_done", 64'(done), 64'd0);
    check("empty_e1_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("empty_e2_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("empty_e3_done",  64'(done),   64'd1);
    check("empty_score",    score,       64'd0);
    check("empty_addr_a",   64'(addr_a), 64'd0);
    check("empty_addr_b",   64'(addr_b), 64'd0);

    // Reset in the middle of a B run clears everything without an edge.
    load_vec(vecs[0]);
    pulse_go();
    edges = 0;
    while (dut.state != RUN_B && edges < BUDGET) begin
      @(posedge clk); #1;
      edges++;
    end
    check("midrst_reach_run_b", 64'(dut.state == RUN_B), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy",   64'(busy),   64'd0);
    check("midrst_done",   64'(done),   64'd0);
    check("midrst_score",  score,       64'd0);
    check("midrst_addr_a", 64'(addr_a), 64'd0);
    check("midrst_addr_b", 64'(addr_b), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run("midrst_rerun", 64'd31, edges);

    // go while busy: no restart, same latency and result.
    load_vec(vecs[0]);
    pulse_go();
    repeat (5) @(posedge clk);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    edges = 7;
    while (!done && edges < BUDGET) begin
      @(posedge clk); #1;
      edges++;
    end
    check("gobusy_latency", 64'(edges), 64'(ref_edges));
    check("gobusy_score",   score,      64'd31);

    // Result holds for 10 idle cycles.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("hold_score", score,      64'd31);
      check("hold_done",  64'(done),  64'd1);
    end

    // A fresh go clears done on its acceptance edge.
    pulse_go();
    check("rego_done", 64'(done), 64'd0);
    check("rego_busy", 64'(busy), 64'd1);
    wait_done("rego", edges);
    check("rego_score", score, 64'd31);

    // Randomized sorted lists against the reference model.
    for (int t = 0; t < 40; t++) begin
      int la, lb;
      fill_junk();
      qa.delete();
      qb.delete();
      la = $urandom_range(0, 12);
      lb = $urandom_range(0, 12);
      for (int k = 0; k < la; k++) begin
        v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 2)
                                         : 32'($urandom_range(0, 6));
        qa.push_back(v);
      end
      for (int k = 0; k < lb; k++) begin
        v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 2)
                                         : 32'($urandom_range(0, 6));
        qb.push_back(v);
      end
      qa.sort();
      qb.sort();
      foreach (qa[k]) mem_a[k] = qa[k];
      foreach (qb[k]) mem_b[k] = qb[k];
      len_a = LEN_W'(la);
      len_b = LEN_W'(lb);
      run($sformatf("rand%0d", t), model(qa, qb), edges);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_similarity_scorer

// File: doc/similarity_scorer.md
# similarity_scorer

Downstream consumer of the in-memory bubble sorter in the day-1 datapath. Once both the left and right lists have been sorted in place, this block walks the two sorted memories with a single merge pass. For every left value v it accumulates v × (number of occurrences of v in the right list), and presents the 64-bit similarity score with a done flag.

## Interface
Parameters:
- `LEN_W`, default 16: width of the list-length inputs and the run counter.
- `ACC_W`, default 64: width of the score accumulator.

Ports:
- `clk`, in, 1: the only clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `go`, in, 1: start pulse. Sampled only in `IDLE`.
- `len_a`, in, `LEN_W`: number of entries in the left (A) memory.
- `len_b`, in, `LEN_W`: number of entries in the right (B) memory.
- `addr_a`, out, 32: read address into A, zero-extended index.
- `data_a`, in, 32: A read data, unsigned.
- `addr_b`, out, 32: read address into B, zero-extended index.
- `data_b`, in, 32: B read data, unsigned.
- `busy`, out, 1: high from the `go` acceptance edge until the final edge.
- `done`, out, 1: level signal. Set on completion and held until the next accepted `go`.
- `score`, out, `ACC_W`: result. Valid while `done` = 1.

## Operation
- Memory model: synchronous read with 1-cycle latency. `data_x` reflects the `addr_x` registered at the previous edge. Both memories are read-only to this block and have no write enable.
- Pointers: `i` drives `addr_a` and `j` drives `addr_b`. Other registers: `key` (32 bits) and `cnt` (`LEN_W` bits).
- States are `IDLE`, `FETCH`, `CMP`, `RUN_B`, `RUN_B_WAIT`, `APPLY_A`, `APPLY_A_WAIT`.
- `IDLE`: on `go`, set i = j = 0, score = 0, done = 0, busy = 1, then go to `FETCH`.
- `FETCH`: wait one cycle, then go to `CMP`.
- `CMP`:
  - If i == `len_a` or j == `len_b`: set done = 1, busy = 0, go to `IDLE`.
  - Else if `data_a` < `data_b`: i += 1, go to `FETCH`.
  - Else if `data_a` > `data_b`: j += 1, go to `FETCH`.
  - Else (equal): key = `data_a`, cnt = 0, go to `RUN_B`.
- `RUN_B`:
  - If j < `len_b` and `data_b` == key: cnt += 1, j += 1, go to `RUN_B_WAIT`.
  - Otherwise go to `APPLY_A`.
  - When j == `len_b`, `data_b` is never compared.
- `RUN_B_WAIT`: go to `RUN_B`.
- `APPLY_A`:
  - If i < `len_a` and `data_a` == key: score += key × cnt, i += 1, go to `APPLY_A_WAIT`.
  - Otherwise go to `CMP`. Both addresses are stable at this point, so the data is already valid.
- `APPLY_A_WAIT`: go to `APPLY_A`.
- Arithmetic:
  - key × cnt is an unsigned 32 × `LEN_W` product, zero-extended to `ACC_W`.
  - The accumulator wraps modulo 2^`ACC_W`.
  - Comparisons are unsigned.

## Timing
- Reset values: `done` = 0, `busy` = 0, `score` = 0, `addr_a` = 0, `addr_b` = 0, state = `IDLE`.
- Reset mid-operation: takes effect immediately and asynchronously, regardless of state. No partial result is retained.
- `go` while busy is ignored. A `go` arriving in the same cycle that `CMP` finishes is also ignored.
- Latency with `len_a` = 0 or `len_b` = 0: counting the `go`-sampling edge as edge 1, `done` rises at edge 3 with score 0.
- Cycle cost in general:
  - 2 cycles per unequal `CMP` step.
  - 2 cycles per matched B entry and per matched A entry.
  - 1 cycle per run exit.
- `score` and `done` remain stable after completion until the next accepted `go` or reset. `len_a` and `len_b` must be stable while busy.
- Addresses never exceed the corresponding length, and data at address = length is never used.

## Structure
- Shared package `aoc_pkg` holds:
  - the `scorer_state_t` enum;
  - `LEN_W`/`ACC_W` defaults;
  - the 32-bit address/data width constants already shared with the sorter.
- Single flat module with no sub-module. The multiply-accumulate stays inline.

## Test plan
- **Example data.** A = [1,2,3,3,3,4], B = [3,3,3,4,5,9] → `done` = 1, `score` = 31.
- **Empty list.** `len_a` = 0, `len_b` = 4 → `done` at edge 3, `score` = 0, `addr_a`/`addr_b` stay 0.
- **Disjoint lists.** A = [1,2], B = [5,6] → `score` = 0. Verify `addr_a` ≤ 2 and `addr_b` ≤ 2 throughout.
- **Width extremes.** A = [FFFFFFFF], B = [FFFFFFFF,FFFFFFFF,FFFFFFFF] → `score` = 0x2_FFFF_FFFD.
- **Reset mid-run.** Assert `reset` low during `RUN_B` of the example run → `busy`, `done`, `score`, and addresses read 0 before the next edge. Rerun `go` → 31.
- **Go while busy / result hold.** Pulse `go` while busy → no restart and the result is unchanged. After `done`, `score` holds 31 for 10 idle cycles. A fresh `go` clears `done` at the next edge.
